ltm_line_prefetch: RTL and testbench
====================================

// Module: ltm_line_prefetch
// PURPOSE
//  Upstream pixel source for the LTM timing controller. Prefetches frame-memory lines into a
//  ping-pong line buffer over a burst read port. Returns iRed/iGreen/iBlue for the controller's
//  coordinate outputs. The active area is 800x480 and coordinates are 1-based.
// PARAMETERS
//  H_ACT   800  active pixels per line; must be a multiple of BURST
//  V_ACT   480  active lines per frame
//  BURST   16   words returned per granted read request
//  ADDR_W  20   width of the memory word address
// PORTS
//  iCLK         in   1       pixel clock, same clock as the timing controller
//  iRST_n       in   1       asynchronous, active-low reset
//  iVD          in   1       active-low vsync from the timing controller; low for one line per frame
//  iCoord_X     in   11      active pixel X, 1..H_ACT
//  iCoord_Y     in   11      active line Y, 1..V_ACT; holds its last value during blanking
//  oRd_req      out  1       burst read request; held high until granted
//  oRd_addr     out  ADDR_W  word address of the burst, = line*H_ACT + word; stable while oRd_req is high
//  iRd_gnt      in   1       one-cycle request acceptance
//  iRd_valid    in   1       read data beat valid
//  iRd_data     in   24      beat data: {R[23:16], G[15:8], B[7:0]}
//  oRed         out  8       pixel red
//  oGreen       out  8       pixel green
//  oBlue        out  8       pixel blue
//  oLine_ready  out  1       line for current display buffer fully loaded
//  oUnderflow   out  1       sticky error flag
// BEHAVIOUR
//  Reset:
//   - All outputs 0, FSM in IDLE, both buffer-full flags cleared.
//   - Display select 0, outstanding-beat count 0.
//  Frame start (iVD registered; falling edge detected):
//   - Abort any fetch in progress.
//   - Target line 0 into buffer 0; clear both full flags.
//   - Go to DRAIN if beats are outstanding, else REQ.
//  Line advance (registered iCoord_Y changes to a value Y in 1..V_ACT):
//   - Display buffer becomes (Y-1)&1.
//   - If Y<V_ACT: start fetching line Y into buffer Y&1, clearing its full flag.
//   - If the FSM is not IDLE at that instant, set oUnderflow and abort the stale fetch (via DRAIN).
//   - Y = 0 is ignored.
//  FSM states:
//   - IDLE: wait for a trigger.
//   - REQ: oRd_req=1. On iRd_gnt, go to WAIT and load the outstanding count with BURST.
//   - WAIT: each iRd_valid writes iRd_data to buf[fill_sel][word] and increments word.
//     At count 0: go to REQ if word<H_ACT; otherwise set full[fill_sel] and go to IDLE.
//   - DRAIN: discard iRd_valid beats until the count reaches 0, then go to REQ for the new target.
//  Beat handling: iRd_valid seen in IDLE or REQ with count 0 is ignored and writes nothing.
//  Read path:
//   - Outputs are registered, 1-cycle latency from iCoord_X.
//   - Data = buf[disp_sel][iCoord_X-1] when full[disp_sel]=1 and 1<=iCoord_X<=H_ACT; else 0.
//   - A read of a non-full buffer with X in range sets oUnderflow.
//  Flags: oLine_ready = full[disp_sel], registered. oUnderflow clears only on reset.
//  Widths and ordering:
//   - Address arithmetic is ADDR_W bits (max 479*800+799 = 383999).
//   - word is an 11-bit counter that wraps to 0 on a new target.
//  Simultaneous events:
//   - Frame start and line advance together: frame start wins.
//   - Grant and abort in the same cycle: the grant counts, so DRAIN expects BURST beats.
// TESTING
//  - Reset mid-WAIT -> next cycle: all outputs 0, oRd_req=0; post-reset beats ignored.
//  - iVD falls, memory grants after 3 cycles with 1-cycle beats -> 50 requests at addr 0,16,..,784;
//    buf0 full; oLine_ready=1 when Y=1.
//  - Y steps 1->2 with line 1 loaded -> X=1 returns word 800's RGB one cycle later;
//    request addr 1600 issued.
//  - Memory stalls (no grant), Y advances -> oUnderflow=1, RGB=0 for that line, stays set.
//  - iVD falls with 10 beats outstanding -> 10 beats discarded, then REQ at addr 0;
//    buffer contents match line 0.
//  - Y=480 reached -> no further requests until the next iVD fall.

Source files
------------

// File: rtl/ltm_line_prefetch_if.sv
// rtl/ltm_line_prefetch_if.sv - burst read port between the line prefetcher and frame memory
interface ltm_line_prefetch_if #(parameter int ADDR_W = 20) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_gnt;
  logic              rd_valid;
  logic [23:0]       rd_data;

  modport master (output rd_req, rd_addr, input rd_gnt, rd_valid, rd_data);
  modport slave  (input rd_req, rd_addr, output rd_gnt, rd_valid, rd_data);
endinterface

// File: rtl/ltm_line_prefetch.sv
// rtl/ltm_line_prefetch.sv - ping-pong line prefetcher feeding pixels to the LTM timing controller
module ltm_line_prefetch #(
  parameter int H_ACT  = 800,
  parameter int V_ACT  = 480,
  parameter int BURST  = 16,
  parameter int ADDR_W = 20
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iVD,
  input  logic [10:0]         iCoord_X,
  input  logic [10:0]         iCoord_Y,
  ltm_line_prefetch_if.master rd,
  output logic [7:0]          oRed,
  output logic [7:0]          oGreen,
  output logic [7:0]          oBlue,
  output logic                oLine_ready,
  output logic                oUnderflow
);
  localparam int CNT_W = $clog2(BURST + 1);
  localparam logic [10:0] H_LAST = 11'(H_ACT);
  localparam logic [10:0] V_LAST = 11'(V_ACT);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [10:0]      word, word_n, tgt_line, y_q;
  logic             fill_sel, disp_sel, tgt_valid, vd_q;
  logic [1:0]       full;
  logic             beat_wr, line_done, busy;
  logic             frame_start, line_adv, y_last, x_ok;
  logic [10:0]      x_m1, wr_idx, rd_idx;
  logic [23:0]      line_buf [0:2*H_ACT-1];

  assign frame_start = vd_q & ~iVD;
  assign line_adv    = (iCoord_Y != y_q) && (iCoord_Y != 11'd0) && (iCoord_Y <= V_LAST);
  assign y_last      = (iCoord_Y == V_LAST);
  assign x_ok        = (iCoord_X != 11'd0) && (iCoord_X <= H_LAST);
  assign x_m1        = iCoord_X - 11'd1;
  assign wr_idx      = fill_sel ? H_LAST + word : word;
  assign rd_idx      = disp_sel ? H_LAST + x_m1 : x_m1;

  assign rd.rd_req  = (state == S_REQ);
  assign rd.rd_addr = ADDR_W'(tgt_line) * ADDR_W'(H_ACT) + ADDR_W'(word);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    word_n    = word;
    beat_wr   = 1'b0;
    line_done = 1'b0;
    unique case (state)
      S_REQ: begin
        if (rd.rd_gnt) begin
          state_n = S_WAIT;
          cnt_n   = BURST_C;
        end
      end
      S_WAIT: begin
        if (rd.rd_valid && cnt != '0) begin
          beat_wr = (word < H_LAST);
          word_n  = word + 11'd1;
          cnt_n   = cnt - ONE_C;
        end
        if (cnt_n == '0) begin
          if (word_n < H_LAST) begin
            state_n = S_REQ;
          end else begin
            state_n   = S_IDLE;
            line_done = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (rd.rd_valid && cnt != '0) cnt_n = cnt - ONE_C;
        if (cnt_n == '0) state_n = tgt_valid ? S_REQ : S_IDLE;
      end
      default: ;
    endcase
  end

  // beats still owed after this cycle, including a grant taken right now
  assign busy = (cnt_n != '0);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      word        <= '0;
      tgt_line    <= '0;
      y_q         <= '0;
      vd_q        <= 1'b1;
      fill_sel    <= 1'b0;
      disp_sel    <= 1'b0;
      tgt_valid   <= 1'b0;
      full        <= 2'b00;
      oRed        <= '0;
      oGreen      <= '0;
      oBlue       <= '0;
      oLine_ready <= 1'b0;
      oUnderflow  <= 1'b0;
    end else begin
      vd_q  <= iVD;
      y_q   <= iCoord_Y;
      state <= state_n;
      cnt   <= cnt_n;
      word  <= word_n;
      if (line_done) full[fill_sel] <= 1'b1;

      if (frame_start) begin
        tgt_line  <= '0;
        fill_sel  <= 1'b0;
        word      <= '0;
        full      <= 2'b00;
        tgt_valid <= 1'b1;
        state     <= busy ? S_DRAIN : S_REQ;
      end else if (line_adv) begin
        disp_sel <= ~iCoord_Y[0];
        if (state != S_IDLE) oUnderflow <= 1'b1;
        if (!y_last) begin
          tgt_line           <= iCoord_Y;
          fill_sel           <= iCoord_Y[0];
          word               <= '0;
          full[iCoord_Y[0]]  <= 1'b0;
          tgt_valid          <= 1'b1;
          state              <= busy ? S_DRAIN : S_REQ;
        end else begin
          tgt_valid <= 1'b0;
          if (state != S_IDLE) state <= busy ? S_DRAIN : S_IDLE;
        end
      end

      if (x_ok && full[disp_sel]) begin
        {oRed, oGreen, oBlue} <= line_buf[rd_idx];
      end else begin
        {oRed, oGreen, oBlue} <= '0;
      end
      if (x_ok && !full[disp_sel]) oUnderflow <= 1'b1;
      oLine_ready <= full[disp_sel];
    end
  end

  always_ff @(posedge iCLK) begin
    if (beat_wr) line_buf[wr_idx] <= rd.rd_data;
  end
endmodule

// File: tb/tb_ltm_line_prefetch.sv
// tb/tb_ltm_line_prefetch.sv - directed bench for ltm_line_prefetch with a burst memory responder
module tb_ltm_line_prefetch;
  localparam int BURST = 16;

  logic        clk, rst_n, vd;
  logic [10:0] coord_x, coord_y;
  logic [7:0]  red, green, blue;
  logic        line_ready, underflow;

  int checks = 0;
  int failures = 0;
  int beats_left = 0;
  int beat_addr = 0;
  int wait_cnt = 0;
  int pause_at = -1;
  int overlap = 0;
  bit mem_en = 0;
  int req_log[$];

  ltm_line_prefetch_if #(.ADDR_W(20)) mif ();

  ltm_line_prefetch dut (
    .iCLK(clk), .iRST_n(rst_n), .iVD(vd), .iCoord_X(coord_x), .iCoord_Y(coord_y),
    .rd(mif), .oRed(red), .oGreen(green), .oBlue(blue),
    .oLine_ready(line_ready), .oUnderflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input logic [19:0] a);
    return {a[7:0], a[15:8], a[7:0] ^ 8'hA5};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // memory: grant after 3 cycles of request, then BURST back-to-back beats
  initial begin
    mif.rd_gnt = 1'b0; mif.rd_valid = 1'b0; mif.rd_data = '0;
    forever begin
      @(negedge clk);
      mif.rd_gnt = 1'b0; mif.rd_valid = 1'b0; mif.rd_data = '0;
      if (mif.rd_req && beats_left > 0) overlap++;
      if (beats_left > 0) begin
        if (beats_left != pause_at) begin
          mif.rd_valid = 1'b1;
          mif.rd_data = pix(20'(beat_addr));
          beat_addr++;
          beats_left--;
        end
      end else if (mem_en && mif.rd_req) begin
        if (wait_cnt == 3) begin
          mif.rd_gnt = 1'b1;
          req_log.push_back(int'(mif.rd_addr));
          beat_addr = int'(mif.rd_addr);
          beats_left = BURST;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] log_at(input int i);
    return (i < req_log.size()) ? 32'(req_log[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_grants(input int n, input string tag);
    int t = 0;
    while (req_log.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (24) @(negedge clk);
    check(tag, 32'(req_log.size()), 32'(n));
  endtask

  task automatic read_px(input int x, input string tag, input logic [23:0] exp);
    coord_x = 11'(x);
    @(negedge clk);
    check(tag, 32'({red, green, blue}), 32'(exp));
    coord_x = 11'd0;
  endtask

  task automatic set_y(input int y);
    coord_y = 11'(y);
    repeat (2) @(negedge clk);
  endtask

  task automatic frame_pulse();
    vd = 1'b0;
    repeat (3) @(negedge clk);
    vd = 1'b1;
  endtask

  initial begin
    int bad;
    int t;
    rst_n = 1'b0; vd = 1'b1; coord_x = '0; coord_y = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(mif.rd_req), 32'd0);
    check("rst_rgb", 32'({red, green, blue}), 32'd0);
    check("rst_ready", 32'(line_ready), 32'd0);
    check("rst_uflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // reset in the middle of a burst
    mem_en = 1;
    frame_pulse();
    t = 0;
    while (!(beats_left > 0 && beats_left < 12) && t < 200) begin
      @(negedge clk);
      t++;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(mif.rd_req), 32'd0);
    check("midrst_addr", 32'(mif.rd_addr), 32'd0);
    check("midrst_rgb", 32'({red, green, blue}), 32'd0);
    check("midrst_ready", 32'(line_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("postrst_grants", 32'(req_log.size()), 32'd1);
    check("postrst_req", 32'(mif.rd_req), 32'd0);
    check("postrst_ready", 32'(line_ready), 32'd0);
    req_log.delete();

    // line 0 after frame start
    frame_pulse();
    wait_grants(50, "l0_grants");
    bad = 0;
    for (int i = 0; i < 50; i++) if (log_at(i) != 32'(i * 16)) bad++;
    check("l0_addr_bad", 32'(bad), 32'd0);
    check("l0_last_addr", log_at(49), 32'd784);
    req_log.delete();
    set_y(1);
    check("y1_ready", 32'(line_ready), 32'd1);
    read_px(1, "y1_x1", 24'h0000A5);
    read_px(800, "y1_x800", 24'h1F03BA);
    read_px(0, "y1_x0", 24'h000000);
    read_px(801, "y1_x801", 24'h000000);
    check("y1_uflow", 32'(underflow), 32'd0);
    wait_grants(50, "l1_grants");
    check("l1_first", log_at(0), 32'd800);

    // line 1 displayed, line 2 fetched
    req_log.delete();
    set_y(2);
    read_px(1, "y2_x1", 24'h200385);
    check("y2_ready", 32'(line_ready), 32'd1);
    wait_grants(50, "l2_grants");
    check("l2_first", log_at(0), 32'd1600);

    // memory stall
    req_log.delete();
    mem_en = 0;
    set_y(3);
    check("stall_req", 32'(mif.rd_req), 32'd1);
    check("stall_addr", 32'(mif.rd_addr), 32'd2400);
    check("stall_uflow0", 32'(underflow), 32'd0);
    set_y(4);
    check("stall_uflow1", 32'(underflow), 32'd1);
    read_px(5, "stall_rgb", 24'h000000);
    check("stall_ready", 32'(line_ready), 32'd0);
    mem_en = 1;
    wait_grants(50, "l4_grants");
    check("l4_first", log_at(0), 32'd3200);
    check("uflow_sticky", 32'(underflow), 32'd1);

    // frame start with 10 beats outstanding
    req_log.delete();
    pause_at = 10;
    set_y(5);
    t = 0;
    while (beats_left != 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_stalled", 32'(beats_left), 32'd10);
    frame_pulse();
    repeat (3) @(negedge clk);
    check("drain_noreq", 32'(mif.rd_req), 32'd0);
    check("drain_grants", 32'(req_log.size()), 32'd1);
    req_log.delete();
    pause_at = -1;
    wait_grants(50, "refetch_grants");
    check("refetch_first", log_at(0), 32'd0);
    check("refetch_overlap", 32'(overlap), 32'd0);
    req_log.delete();
    set_y(1);
    read_px(1, "rf_x1", 24'h0000A5);
    read_px(400, "rf_x400", 24'h8F012A);
    read_px(800, "rf_x800", 24'h1F03BA);
    wait_grants(50, "rf_l1_grants");

    // last line and end of frame
    req_log.delete();
    set_y(479);
    wait_grants(50, "l479_grants");
    check("l479_first", log_at(0), 32'd383200);
    check("l479_last", log_at(49), 32'd383984);
    req_log.delete();
    set_y(480);
    repeat (200) @(negedge clk);
    check("y480_grants", 32'(req_log.size()), 32'd0);
    check("y480_req", 32'(mif.rd_req), 32'd0);
    check("y480_ready", 32'(line_ready), 32'd1);
    read_px(800, "y480_x800", 24'hFFDB5A);
    frame_pulse();
    t = 0;
    while (req_log.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("nextframe_first", log_at(0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
